// File: rtl/lm80c_mem_write_arbiter_if.sv
// Write-request bundle between the downloader/eraser/Z80 side and the dpram port-A arbiter.
// The master modport is the requester side; the slave modport is the arbiter.
interface lm80c_mem_write_arbiter_if #(
   parameter int ROM_AW = 15,
   parameter int RAM_AW = 16
);
   logic              dl_req;
   logic [24:0]       dl_addr;
   logic [7:0]        dl_data;
   logic              dl_busy;
   logic              er_req;
   logic [24:0]       er_addr;
   logic [7:0]        er_data;
   logic              er_busy;
   logic              cpu_req;
   logic [15:0]       cpu_addr;
   logic [7:0]        cpu_data;
   logic              cpu_busy;
   logic              rom_enabled;
   logic              rom_wr;
   logic [ROM_AW-1:0] rom_addr;
   logic [7:0]        rom_data;
   logic              ram_wr;
   logic [RAM_AW-1:0] ram_addr;
   logic [7:0]        ram_data;
   logic [2:0]        done;
   logic [2:0]        ovf;

   modport master (
      output dl_req, dl_addr, dl_data, er_req, er_addr, er_data,
             cpu_req, cpu_addr, cpu_data, rom_enabled,
      input  dl_busy, er_busy, cpu_busy, rom_wr, rom_addr, rom_data,
             ram_wr, ram_addr, ram_data, done, ovf
   );

   modport slave (
      input  dl_req, dl_addr, dl_data, er_req, er_addr, er_data,
             cpu_req, cpu_addr, cpu_data, rom_enabled,
      output dl_busy, er_busy, cpu_busy, rom_wr, rom_addr, rom_data,
             ram_wr, ram_addr, ram_data, done, ovf
   );
endinterface

// File: rtl/lm80c_mem_write_arbiter.sv
// Registered fixed-priority arbiter (dl > er > cpu, CPU anti-starvation) for the ROM/RAM dpram write ports.
// Optional LM80C_ARB_STATS_EN adds saturating stall_cnt/drop_cnt statistics outputs.
module lm80c_mem_write_arbiter #(
   parameter int CPU_MAX_WAIT = 8,
   parameter int ROM_AW       = 15,
   parameter int RAM_AW       = 16
) (
   input logic clk_sys,
   input logic reset,
   lm80c_mem_write_arbiter_if.slave bus
`ifdef LM80C_ARB_STATS_EN
   ,
   output logic [15:0] stall_cnt,
   output logic [7:0]  drop_cnt
`endif
);

   localparam logic [7:0] MAX_WAIT = 8'(CPU_MAX_WAIT);
   localparam int DL  = 0;
   localparam int ER  = 1;
   localparam int CPU = 2;

   typedef struct packed {
      logic              valid;
      logic              rom;
      logic [RAM_AW-1:0] addr;
      logic [7:0]        data;
   } slot_t;

   slot_t             slot_q [3];
   slot_t             cap    [3];
   slot_t             gslot;
   logic [2:0]        hit;
   logic [2:0]        discard;
   logic [2:0]        full;
   logic [2:0]        grant;
   logic              cpu_prot;
   logic [7:0]        wait_q;
   logic [2:0]        ovf_q;
   logic [2:0]        done_q;
   logic              rom_wr_q;
   logic              ram_wr_q;
   logic [ROM_AW-1:0] rom_addr_q;
   logic [7:0]        rom_data_q;
   logic [RAM_AW-1:0] ram_addr_q;
   logic [7:0]        ram_data_q;

   function automatic logic in_rom(input logic [24:0] a);
      return a < 25'h0008000;
   endfunction

   function automatic logic in_ram(input logic [24:0] a);
      return (a >= 25'h0010000) && (a < 25'h0020000);
   endfunction

   // Capture-side decode; external ROM hits keep bit 15 clear so the shared addr field is safe.
   always_comb begin
      // NOTE: combinational outputs get a default first so no branch can leave one unassigned (no latch).
      cap[DL]      = '{valid: 1'b1, rom: in_rom(bus.dl_addr),
                       addr: bus.dl_addr[RAM_AW-1:0], data: bus.dl_data};
      cap[ER]      = '{valid: 1'b1, rom: in_rom(bus.er_addr),
                       addr: bus.er_addr[RAM_AW-1:0], data: bus.er_data};
      cap[CPU]     = '{valid: 1'b1, rom: 1'b0,
                       addr: bus.cpu_addr[RAM_AW-1:0], data: bus.cpu_data};
      cpu_prot     = bus.rom_enabled && (bus.cpu_addr < 16'h8000);
      hit          = '0;
      discard      = '0;
      hit[DL]      = bus.dl_req && (in_rom(bus.dl_addr) || in_ram(bus.dl_addr));
      discard[DL]  = bus.dl_req && !(in_rom(bus.dl_addr) || in_ram(bus.dl_addr));
      hit[ER]      = bus.er_req && (in_rom(bus.er_addr) || in_ram(bus.er_addr));
      discard[ER]  = bus.er_req && !(in_rom(bus.er_addr) || in_ram(bus.er_addr));
      hit[CPU]     = bus.cpu_req && !cpu_prot;
      discard[CPU] = bus.cpu_req && cpu_prot;
   end

   assign full = {slot_q[CPU].valid, slot_q[ER].valid, slot_q[DL].valid};

   always_comb begin
      grant = '0;
      gslot = '0;
      if (full[CPU] && (wait_q == MAX_WAIT)) grant = 3'b100;
      else if (full[DL])                     grant = 3'b001;
      else if (full[ER])                     grant = 3'b010;
      else if (full[CPU])                    grant = 3'b100;
      if (grant[DL])  gslot = slot_q[DL];
      if (grant[ER])  gslot = slot_q[ER];
      if (grant[CPU]) gslot = slot_q[CPU];
   end

   // A slot being granted this cycle may take a new request in the same edge without overflowing.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         // NOTE: the slots are a handful of flops whose valid bits must clear on reset, not a RAM array.
         for (int i = 0; i < 3; i++) slot_q[i] <= '0;
         ovf_q <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            // NOTE: sequential state is updated with non-blocking assignments only.
            if (hit[i] && (!full[i] || grant[i])) slot_q[i] <= cap[i];
            else if (grant[i])                    slot_q[i].valid <= 1'b0;
            if (hit[i] && full[i] && !grant[i])   ovf_q[i] <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         rom_wr_q   <= 1'b0;
         ram_wr_q   <= 1'b0;
         rom_addr_q <= '0;
         rom_data_q <= '0;
         ram_addr_q <= '0;
         ram_data_q <= '0;
         done_q     <= '0;
      end else begin
         rom_wr_q <= (|grant) && gslot.rom;
         ram_wr_q <= (|grant) && !gslot.rom;
         done_q   <= grant;
         if ((|grant) && gslot.rom) begin
            rom_addr_q <= gslot.addr[ROM_AW-1:0];
            rom_data_q <= gslot.data;
         end
         if ((|grant) && !gslot.rom) begin
            ram_addr_q <= gslot.addr;
            ram_data_q <= gslot.data;
         end
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset)                        wait_q <= '0;
      else if (!full[CPU] || grant[CPU]) wait_q <= '0;
      else if (wait_q != MAX_WAIT)      wait_q <= wait_q + 8'd1;
   end

`ifdef LM80C_ARB_STATS_EN
   logic [1:0] drop_inc;
   logic [8:0] drop_sum;

   assign drop_inc = 2'(discard[DL]) + 2'(discard[ER]) + 2'(discard[CPU]);
   assign drop_sum = {1'b0, drop_cnt} + 9'(drop_inc);

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         stall_cnt <= '0;
         drop_cnt  <= '0;
      end else begin
         if ((|(full & ~grant)) && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
         drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      end
   end
`endif

   assign bus.dl_busy  = full[DL];
   assign bus.er_busy  = full[ER];
   assign bus.cpu_busy = full[CPU];
   assign bus.rom_wr   = rom_wr_q;
   assign bus.rom_addr = rom_addr_q;
   assign bus.rom_data = rom_data_q;
   assign bus.ram_wr   = ram_wr_q;
   assign bus.ram_addr = ram_addr_q;
   assign bus.ram_data = ram_data_q;
   assign bus.done     = done_q;
   assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_lm80c_mem_write_arbiter.sv
// Directed self-checking bench for lm80c_mem_write_arbiter (default build, CPU_MAX_WAIT = 8).
module tb_lm80c_mem_write_arbiter;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   lm80c_mem_write_arbiter_if bus_if ();

`ifdef LM80C_ARB_STATS_EN
   logic [15:0] stall_cnt;
   logic [7:0]  drop_cnt;
`endif

   lm80c_mem_write_arbiter #(
      .CPU_MAX_WAIT(8),
      .ROM_AW(15),
      .RAM_AW(16)
   ) dut (
      .clk_sys(clk),
      .reset(rst),
      .bus(bus_if)
`ifdef LM80C_ARB_STATS_EN
      ,
      .stall_cnt(stall_cnt),
      .drop_cnt(drop_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      bus_if.dl_req  = 1'b0;
      bus_if.er_req  = 1'b0;
      bus_if.cpu_req = 1'b0;
   endtask

   task automatic do_reset();
      clear_in();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   function automatic logic [2:0] busy3();
      return {bus_if.cpu_busy, bus_if.er_busy, bus_if.dl_busy};
   endfunction

   int cpu_cycle;
   int rom_cnt;
   int hit_first;
   int hit_second;
   int wr_cnt;
   logic [14:0] addr13;
   logic [14:0] addr14;
   logic [7:0]  cpu_wdata;

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus_if.dl_addr     = '0;
      bus_if.dl_data     = '0;
      bus_if.er_addr     = '0;
      bus_if.er_data     = '0;
      bus_if.cpu_addr    = '0;
      bus_if.cpu_data    = '0;
      bus_if.rom_enabled = 1'b0;
      do_reset();

      // Reset state
      check("rst_rom_wr",   32'(bus_if.rom_wr),   32'h0);
      check("rst_ram_wr",   32'(bus_if.ram_wr),   32'h0);
      check("rst_rom_addr", 32'(bus_if.rom_addr), 32'h0);
      check("rst_ram_addr", 32'(bus_if.ram_addr), 32'h0);
      check("rst_done",     32'(bus_if.done),     32'h0);
      check("rst_ovf",      32'(bus_if.ovf),      32'h0);
      check("rst_busy",     32'(busy3()),         32'h0);

      // Downloader only: ROM then RAM, each two cycles after its request
      bus_if.dl_req = 1'b1; bus_if.dl_addr = 25'h0000010; bus_if.dl_data = 8'hA5;
      tick(); clear_in();
      check("dl1_busy", 32'(busy3()), 32'h1);
      tick();
      check("dl1_rom_wr",   32'(bus_if.rom_wr),   32'h1);
      check("dl1_ram_wr",   32'(bus_if.ram_wr),   32'h0);
      check("dl1_rom_addr", 32'(bus_if.rom_addr), 32'h0010);
      check("dl1_rom_data", 32'(bus_if.rom_data), 32'hA5);
      check("dl1_done",     32'(bus_if.done),     32'h1);
      check("dl1_busy_clr", 32'(busy3()),         32'h0);
      bus_if.dl_req = 1'b1; bus_if.dl_addr = 25'h0015608; bus_if.dl_data = 8'h3C;
      tick(); clear_in();
      check("dl2_rom_wr_single", 32'(bus_if.rom_wr),   32'h0);
      check("dl2_rom_addr_hold", 32'(bus_if.rom_addr), 32'h0010);
      check("dl2_done_single",   32'(bus_if.done),     32'h0);
      tick();
      check("dl2_ram_wr",   32'(bus_if.ram_wr),   32'h1);
      check("dl2_rom_wr",   32'(bus_if.rom_wr),   32'h0);
      check("dl2_ram_addr", 32'(bus_if.ram_addr), 32'h5608);
      check("dl2_ram_data", 32'(bus_if.ram_data), 32'h3C);
      check("dl2_done",     32'(bus_if.done),     32'h1);
      tick();

      // Contention: all three in the same cycle drain dl, er, cpu in consecutive cycles
      bus_if.dl_req  = 1'b1; bus_if.dl_addr  = 25'h0000001; bus_if.dl_data  = 8'h11;
      bus_if.er_req  = 1'b1; bus_if.er_addr  = 25'h0010002; bus_if.er_data  = 8'h22;
      bus_if.cpu_req = 1'b1; bus_if.cpu_addr = 16'h9000;    bus_if.cpu_data = 8'h33;
      tick(); clear_in();
      check("con_busy", 32'(busy3()), 32'h7);
      tick();
      check("con1_rom_wr",   32'(bus_if.rom_wr),   32'h1);
      check("con1_rom_addr", 32'(bus_if.rom_addr), 32'h0001);
      check("con1_done",     32'(bus_if.done),     32'h1);
      tick();
      check("con2_ram_wr",   32'(bus_if.ram_wr),   32'h1);
      check("con2_ram_addr", 32'(bus_if.ram_addr), 32'h0002);
      check("con2_ram_data", 32'(bus_if.ram_data), 32'h22);
      check("con2_done",     32'(bus_if.done),     32'h2);
      tick();
      check("con3_ram_wr",   32'(bus_if.ram_wr),   32'h1);
      check("con3_ram_addr", 32'(bus_if.ram_addr), 32'h9000);
      check("con3_ram_data", 32'(bus_if.ram_data), 32'h33);
      check("con3_done",     32'(bus_if.done),     32'h4);
      check("con_ovf",       32'(bus_if.ovf),      32'h0);
      tick();

      // Starvation: cpu req in cycle 2 while dl streams; forced grant gives the write in cycle 12
      do_reset();
      cpu_cycle = -1; rom_cnt = 0; cpu_wdata = '0; addr13 = '0; addr14 = '0;
      for (int c = 0; c < 30; c++) begin
         bus_if.dl_req   = 1'b1;
         bus_if.dl_addr  = 25'h0000100 + 25'(c);
         bus_if.dl_data  = 8'(c);
         bus_if.cpu_req  = (c == 2);
         bus_if.cpu_addr = 16'h9000;
         bus_if.cpu_data = 8'h77;
         tick();
         if (bus_if.ram_wr && (bus_if.ram_addr == 16'h9000) && (cpu_cycle < 0)) begin
            cpu_cycle = c + 1;
            cpu_wdata = bus_if.ram_data;
         end
         if (bus_if.rom_wr) rom_cnt++;
         if (c + 1 == 13) addr13 = bus_if.rom_addr;
         if (c + 1 == 14) addr14 = bus_if.rom_addr;
      end
      clear_in();
      check("starve_cpu_cycle", 32'(cpu_cycle), 32'd12);
      check("starve_cpu_data",  32'(cpu_wdata), 32'h77);
      check("starve_dl_writes", 32'(rom_cnt),   32'd28);
      check("starve_addr13",    32'(addr13),    32'h010A);
      check("starve_addr14",    32'(addr14),    32'h010C);
      check("starve_ovf",       32'(bus_if.ovf), 32'h1);
      tick(); tick(); tick();

      // Overflow: back-to-back cpu reqs while dl streams; only the first is written
      do_reset();
      hit_first = 0; hit_second = 0;
      for (int c = 0; c < 20; c++) begin
         bus_if.dl_req   = 1'b1;
         bus_if.dl_addr  = 25'h0000200 + 25'(c);
         bus_if.dl_data  = 8'(c);
         bus_if.cpu_req  = (c == 2) || (c == 3);
         bus_if.cpu_addr = (c == 2) ? 16'h9001 : 16'h9002;
         bus_if.cpu_data = (c == 2) ? 8'h55 : 8'h66;
         tick();
         if (bus_if.ram_wr && (bus_if.ram_addr == 16'h9001) && (bus_if.ram_data == 8'h55)) hit_first++;
         if (bus_if.ram_wr && (bus_if.ram_addr == 16'h9002)) hit_second++;
      end
      clear_in();
      tick(); tick(); tick();
      check("ovf_cpu_flag",     32'(bus_if.ovf[2]), 32'h1);
      check("ovf_first_written", 32'(hit_first),    32'd1);
      check("ovf_second_dropped", 32'(hit_second),  32'd0);

      // Decode: protected CPU window, unprotected CPU RAM write, external out-of-range and edges
      do_reset();
      bus_if.rom_enabled = 1'b1;
      bus_if.cpu_req = 1'b1; bus_if.cpu_addr = 16'h1234; bus_if.cpu_data = 8'hAB;
      tick(); clear_in();
      check("dec_prot_busy", 32'(busy3()), 32'h0);
      tick();
      check("dec_prot_ram_wr", 32'(bus_if.ram_wr), 32'h0);
      check("dec_prot_done",   32'(bus_if.done),   32'h0);
      bus_if.rom_enabled = 1'b0;
      bus_if.cpu_req = 1'b1; bus_if.cpu_addr = 16'h1234; bus_if.cpu_data = 8'hCD;
      tick(); clear_in();
      check("dec_cpu_busy", 32'(busy3()), 32'h4);
      tick();
      check("dec_cpu_ram_wr",   32'(bus_if.ram_wr),   32'h1);
      check("dec_cpu_ram_addr", 32'(bus_if.ram_addr), 32'h1234);
      check("dec_cpu_ram_data", 32'(bus_if.ram_data), 32'hCD);
      check("dec_cpu_done",     32'(bus_if.done),     32'h4);
      bus_if.dl_req = 1'b1; bus_if.dl_addr = 25'h000A000; bus_if.dl_data = 8'h99;
      tick(); clear_in();
      check("dec_dl_oor_busy", 32'(busy3()), 32'h0);
      tick();
      check("dec_dl_oor_wr",   32'({bus_if.rom_wr, bus_if.ram_wr}), 32'h0);
      check("dec_dl_oor_done", 32'(bus_if.done), 32'h0);
      bus_if.er_req = 1'b1; bus_if.er_addr = 25'h0007FFF; bus_if.er_data = 8'h5A;
      tick(); clear_in(); tick();
      check("dec_er_rom_top_wr",   32'(bus_if.rom_wr),   32'h1);
      check("dec_er_rom_top_addr", 32'(bus_if.rom_addr), 32'h7FFF);
      check("dec_er_rom_top_done", 32'(bus_if.done),     32'h2);
      bus_if.er_req = 1'b1; bus_if.er_addr = 25'h0008000; bus_if.er_data = 8'h5B;
      tick(); clear_in(); tick();
      check("dec_er_8000_drop", 32'({bus_if.rom_wr, bus_if.ram_wr, bus_if.done}), 32'h0);
      bus_if.er_req = 1'b1; bus_if.er_addr = 25'h001FFFF; bus_if.er_data = 8'h6B;
      tick(); clear_in(); tick();
      check("dec_er_ram_top_wr",   32'(bus_if.ram_wr),   32'h1);
      check("dec_er_ram_top_addr", 32'(bus_if.ram_addr), 32'hFFFF);
      bus_if.er_req = 1'b1; bus_if.er_addr = 25'h0020000; bus_if.er_data = 8'h6C;
      tick(); clear_in(); tick();
      check("dec_er_20000_drop", 32'({bus_if.rom_wr, bus_if.ram_wr, bus_if.done}), 32'h0);
      check("dec_ovf", 32'(bus_if.ovf), 32'h0);

      // Reset mid-operation: all slots full, async reset clears everything, nothing issued after
      bus_if.dl_req  = 1'b1; bus_if.dl_addr  = 25'h0000040; bus_if.dl_data  = 8'h01;
      bus_if.er_req  = 1'b1; bus_if.er_addr  = 25'h0010040; bus_if.er_data  = 8'h02;
      bus_if.cpu_req = 1'b1; bus_if.cpu_addr = 16'hA000;    bus_if.cpu_data = 8'h03;
      tick(); clear_in();
      check("rmid_busy_full", 32'(busy3()), 32'h7);
      rst = 1'b1;
      #1;
      check("rmid_busy_clr", 32'(busy3()), 32'h0);
      check("rmid_wr_clr",   32'({bus_if.rom_wr, bus_if.ram_wr}), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      wr_cnt = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (bus_if.rom_wr || bus_if.ram_wr || (bus_if.done != 3'b000)) wr_cnt++;
      end
      check("rmid_no_writes", 32'(wr_cnt),  32'd0);
      check("rmid_busy_post", 32'(busy3()), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lm80c_mem_write_arbiter.md
Name: lm80c_mem_write_arbiter

Overview:
- Serialises write requests from the downloader, the eraser and the Z80 onto the on-chip 32 KB ROM and 64 KB RAM dpram write ports (port A).
- Each requester gets a one-entry holding slot, so a write that loses arbitration is held, not dropped.
- Priority is fixed: downloader, then eraser, then CPU. A CPU anti-starvation timer overrides this priority.
- Sits between the downloader/eraser/lm80c core and the dpram instances; replaces the combinational write mux.

Parameters:
- CPU_MAX_WAIT, 8: cycles a pending CPU write may wait before it is forced to highest priority (1..255).
- ROM_AW, 15: ROM address width.
- RAM_AW, 16: RAM address width.

Ports:
- clk_sys  in  1  system clock (42.954545 MHz).
- reset  in  1  asynchronous, active-high reset.
- dl_req  in  1  downloader write strobe, one cycle per byte.
- dl_addr  in  25  downloader byte address.
- dl_data  in  8  downloader data.
- dl_busy  out  1  downloader slot full.
- er_req  in  1  eraser write strobe.
- er_addr  in  25  eraser address.
- er_data  in  8  eraser data.
- er_busy  out  1  eraser slot full.
- cpu_req  in  1  CPU write strobe; must be single-cycle per write.
- cpu_addr  in  16  CPU address.
- cpu_data  in  8  CPU data.
- cpu_busy  out  1  CPU slot full.
- rom_enabled  in  1  PIO port B bit 0; qualifies CPU decode.
- rom_wr  out  1  ROM write enable.
- rom_addr  out  15  ROM write address.
- rom_data  out  8  ROM write data.
- ram_wr  out  1  RAM write enable.
- ram_addr  out  16  RAM write address.
- ram_data  out  8  RAM write data.
- done  out  3  one-cycle grant pulse per requester {cpu,er,dl}.
- ovf  out  3  sticky overflow per requester {cpu,er,dl}.

Behaviour:
- Reset (async, active-high): all slots empty; all outputs 0 (rom_wr, ram_wr, addresses, data, done, ovf, busy); CPU wait counter 0.
- Capture at the rising edge where req=1:
  - The address is decoded and the write is stored in the slot with target ROM or RAM.
  - Downloader and eraser decode: addr < 0x08000 targets ROM, using addr[14:0]. 0x10000 <= addr < 0x20000 targets RAM, using addr[15:0]. Any other address is discarded at capture, with no slot entry and no done pulse.
  - CPU decode: target is always RAM at cpu_addr. If rom_enabled=1 and cpu_addr < 0x8000, the write is discarded (ROM window is read-only).
- Arbitration: a registered single grant per cycle.
  - Normal order: dl > er > cpu.
  - If the CPU slot is full and its wait counter equals CPU_MAX_WAIT, the CPU wins that cycle.
- Grant cycle N: the slot is freed and done[i] pulses in cycle N+1. In the same cycle N+1 exactly one of rom_wr/ram_wr is 1, with its addr/data; the other strobe is 0.
- Latency: a req captured at edge N reaches the write port at the earliest in cycle N+2, and only if uncontended.
- Write strobes are single-cycle. Address/data outputs hold their last value when there is no write.
- busy[i] = slot i full. It is registered and asserted in the cycle after capture.
- Simultaneous grant and new req on the same slot: the new request is captured and the slot stays full; no overflow.
- req while the slot is full and not granted that cycle: the new request is dropped and ovf[i] is set. ovf clears only on reset.
- CPU wait counter: increments each cycle the CPU slot is full and not granted, saturating at CPU_MAX_WAIT. It is cleared when the CPU is granted or the slot is empty.
- A reset asserted mid-operation discards all pending slots immediately. No partial write is issued after reset release.

Optional Feature:
- Macro LM80C_ARB_STATS_EN.
- When defined, adds two outputs:
  - stall_cnt[15:0]: cycles in which at least one slot was full and not granted.
  - drop_cnt[7:0]: count of out-of-range or protected discards.
- Both counters saturate and clear on reset.
- When not defined, these ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Downloader only: dl_req with addr 0x00010/data 0xA5, then 0x15608/0x3C. Expect rom_wr with rom_addr=0x0010/0xA5, then ram_wr with ram_addr=0x5608/0x3C, each 2 cycles after its req; done[0] pulses.
- Contention: dl_req, er_req and cpu_req in the same cycle (0x00001, 0x10002, 0x9000). Expect writes in consecutive cycles in order dl, er, cpu; no ovf.
- Starvation, CPU_MAX_WAIT=8: dl_req every cycle plus one cpu_req 0x9000/0x77. Expect the CPU write issued no later than 10 cycles after its req; downloader sustains 1 write/cycle except that slot.
- Overflow: two cpu_req in back-to-back cycles while the downloader streams. Expect ovf[2]=1 and only the first CPU byte written.
- Decode: rom_enabled=1 with cpu_req 0x1234 -> no write. rom_enabled=0 with cpu_req 0x1234 -> ram_wr, ram_addr=0x1234. dl_req 0x0A000 -> discarded, no done.
- Reset mid-op: fill all three slots, assert reset for 1 cycle. Expect rom_wr/ram_wr=0 and busy=0, with no writes after release.
